// File: rtl/rvfi_commit_checker_if.sv
// Retirement bus observed by rvfi_commit_checker: per-lane commit strobe,
// order, instruction word and PC pair, packed lane 0 in the low bits.
interface rvfi_commit_checker_if #(
    parameter int NRET = 2
);
    logic [NRET-1:0]    valid;
    logic [NRET*64-1:0] order;
    logic [NRET*32-1:0] inst;
    logic [NRET*32-1:0] pc_rdata;
    logic [NRET*32-1:0] pc_wdata;

    modport master (output valid, order, inst, pc_rdata, pc_wdata);
    modport slave  (input  valid, order, inst, pc_rdata, pc_wdata);
endinterface

// File: rtl/rvfi_commit_checker.sv
// Retirement-stream checker: sticky lane-gap/order/PC-chain/X errors, halt
// detection, and a start/stop-marker bounded instruction/cycle measurement.
module rvfi_commit_checker #(
    parameter int NRET     = 2,
    parameter int CNT_W    = 64,
    parameter bit CHECK_PC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    rvfi_commit_checker_if.slave rvfi,
    output logic [3:0]           err_code,
    output logic                 error,
    output logic                 halt,
    output logic [CNT_W-1:0]     inst_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [1:0]           meas_state
);
    localparam int LW = $clog2(NRET + 1);
    localparam int IW = (NRET > 1) ? $clog2(NRET) : 1;

    localparam logic [31:0] INST_BEQ   = 32'h0000_0063;
    localparam logic [31:0] INST_JAL   = 32'h0000_006f;
    localparam logic [31:0] INST_START = 32'h0010_2013;
    localparam logic [31:0] INST_STOP  = 32'h0020_2013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } meas_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [LW-1:0]    b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W + 1 - LW){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [3:0]       r_err_code;
    logic             r_halt;
    logic [63:0]      r_exp_order;
    logic [31:0]      r_last_pc;
    logic             r_last_pc_vld;
    meas_e            r_state;
    logic [CNT_W-1:0] r_inst_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic             w_x_valid;
    logic             w_x_data;
    logic [NRET-1:0]  w_valid;
    logic [NRET:0]    w_valid_p1;
    logic             w_gap;
    logic             w_order_err;
    logic             w_pc_err;
    logic             w_post_err;
    logic [LW-1:0]    w_cnt;
    logic [31:0]      w_last_pc_nxt;
    logic             w_lane_halt;
    logic             w_halt_hit;
    logic [IW-1:0]    w_halt_lane;
    logic             w_start_hit;
    logic [IW-1:0]    w_start_lane;
    logic             w_stop_hit;
    logic [IW-1:0]    w_stop_lane;
    logic             w_same_cycle;
    logic [LW-1:0]    w_above_start;
    logic [LW-1:0]    w_upto_stop;
    meas_e            w_state_nxt;
    logic [CNT_W-1:0] w_inst_nxt;
    logic [CNT_W-1:0] w_cycle_nxt;

    // Per-cycle commit analysis; a strobe containing X is treated as no commit.
    always_comb begin
        w_x_valid     = $isunknown(rvfi.valid);
        w_valid       = w_x_valid ? {NRET{1'b0}} : rvfi.valid;
        w_valid_p1    = {1'b0, w_valid} + {{NRET{1'b0}}, 1'b1};
        w_gap         = |({1'b0, w_valid} & w_valid_p1);
        w_x_data      = 1'b0;
        w_order_err   = 1'b0;
        w_pc_err      = 1'b0;
        w_cnt         = {LW{1'b0}};
        w_last_pc_nxt = r_last_pc;
        for (int i = 0; i < NRET; i++) begin
            w_x_data = w_x_data | (w_valid[i] & ($isunknown(rvfi.order[64*i +: 64])
                                               | $isunknown(rvfi.inst[32*i +: 32])
                                               | $isunknown(rvfi.pc_rdata[32*i +: 32])
                                               | $isunknown(rvfi.pc_wdata[32*i +: 32])));
            w_order_err   = w_order_err | (w_valid[i] & (rvfi.order[64*i +: 64] != (r_exp_order + 64'(i))));
            w_cnt         = w_cnt + LW'(w_valid[i]);
            w_last_pc_nxt = w_valid[i] ? rvfi.pc_wdata[32*i +: 32] : w_last_pc_nxt;
        end
        for (int i = 1; i < NRET; i++) begin
            w_pc_err = w_pc_err | (w_valid[i] & w_valid[i-1]
                                   & (rvfi.pc_rdata[32*i +: 32] != rvfi.pc_wdata[32*(i-1) +: 32]));
        end
        w_pc_err = w_pc_err | (w_valid[0] & r_last_pc_vld & (rvfi.pc_rdata[31:0] != r_last_pc));
    end

    // Lowest halting / start / stop lanes (descending scan leaves the lowest hit).
    always_comb begin
        w_lane_halt  = 1'b0;
        w_halt_hit   = 1'b0;
        w_halt_lane  = {IW{1'b0}};
        w_start_hit  = 1'b0;
        w_start_lane = {IW{1'b0}};
        w_stop_hit   = 1'b0;
        w_stop_lane  = {IW{1'b0}};
        for (int i = NRET - 1; i >= 0; i--) begin
            w_lane_halt  = w_valid[i] & ((rvfi.pc_rdata[32*i +: 32] == rvfi.pc_wdata[32*i +: 32])
                                         | (rvfi.inst[32*i +: 32] == INST_BEQ)
                                         | (rvfi.inst[32*i +: 32] == INST_JAL));
            w_halt_hit   = w_halt_hit | w_lane_halt;
            w_halt_lane  = w_lane_halt ? IW'(i) : w_halt_lane;
            w_start_hit  = w_start_hit | (w_valid[i] & (rvfi.inst[32*i +: 32] == INST_START));
            w_start_lane = (w_valid[i] & (rvfi.inst[32*i +: 32] == INST_START)) ? IW'(i) : w_start_lane;
            w_stop_hit   = w_stop_hit | (w_valid[i] & (rvfi.inst[32*i +: 32] == INST_STOP));
            w_stop_lane  = (w_valid[i] & (rvfi.inst[32*i +: 32] == INST_STOP)) ? IW'(i) : w_stop_lane;
        end
    end

    // Post-halt commits and the lane counts that seed/close a measurement.
    always_comb begin
        w_post_err    = r_halt & (|w_valid);
        w_above_start = {LW{1'b0}};
        w_upto_stop   = {LW{1'b0}};
        for (int i = 0; i < NRET; i++) begin
            w_post_err    = w_post_err | (w_valid[i] & w_halt_hit & (IW'(i) > w_halt_lane));
            w_above_start = w_above_start + LW'(w_valid[i] & (IW'(i) > w_start_lane));
            w_upto_stop   = w_upto_stop + LW'(w_valid[i] & (IW'(i) <= w_stop_lane));
        end
        w_same_cycle = w_start_hit & w_stop_hit & (w_stop_lane > w_start_lane);
    end

    // Checker state: sticky errors, halt, expected order and PC chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_code    <= 4'b0000;
            r_halt        <= 1'b0;
            r_exp_order   <= 64'd0;
            r_last_pc     <= 32'd0;
            r_last_pc_vld <= 1'b0;
        end else begin
            r_err_code    <= r_err_code | {w_x_valid | w_x_data, w_pc_err & CHECK_PC,
                                           w_order_err | w_post_err, w_gap};
            r_halt        <= r_halt | w_halt_hit;
            r_exp_order   <= r_exp_order + 64'(w_cnt);
            r_last_pc     <= w_last_pc_nxt;
            r_last_pc_vld <= r_last_pc_vld | (|w_valid);
        end
    end

    // Measurement FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Measurement FSM next state; a start marker restarts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_same_cycle) begin
            w_state_nxt = ST_DONE;
        end else if (w_start_hit) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RUN:  w_state_nxt = w_stop_hit ? ST_DONE : ST_RUN;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Measurement FSM outputs: next counter values, saturating.
    always_comb begin
        w_inst_nxt  = r_inst_cnt;
        w_cycle_nxt = r_cycle_cnt;
        if (w_same_cycle) begin
            w_inst_nxt  = CNT_W'(w_stop_lane - w_start_lane);
            w_cycle_nxt = {CNT_W{1'b0}};
        end else if (w_start_hit) begin
            w_inst_nxt  = CNT_W'(w_above_start);
            w_cycle_nxt = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_inst_nxt  = sat_add(r_inst_cnt, w_cnt);
                    w_cycle_nxt = sat_add(r_cycle_cnt, LW'(1));
                end
                ST_RUN: begin
                    w_inst_nxt  = sat_add(r_inst_cnt, w_stop_hit ? w_upto_stop : w_cnt);
                    w_cycle_nxt = sat_add(r_cycle_cnt, LW'(1));
                end
                ST_DONE: begin
                    w_inst_nxt  = r_inst_cnt;
                    w_cycle_nxt = r_cycle_cnt;
                end
                default: begin
                    w_inst_nxt  = {CNT_W{1'b0}};
                    w_cycle_nxt = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_cnt  <= {CNT_W{1'b0}};
            r_cycle_cnt <= {CNT_W{1'b0}};
        end else begin
            r_inst_cnt  <= w_inst_nxt;
            r_cycle_cnt <= w_cycle_nxt;
        end
    end

    assign err_code    = r_err_code;
    assign error       = |r_err_code;
    assign halt        = r_halt;
    assign inst_count  = r_inst_cnt;
    assign cycle_count = r_cycle_cnt;
    assign meas_state  = r_state;
endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Directed bench for rvfi_commit_checker (NRET=2); a second 4-bit-counter
// instance on the same bus exercises counter saturation.
module tb_rvfi_commit_checker;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL   = 32'h0000_006f;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] START = 32'h0010_2013;
    localparam logic [31:0] STOP  = 32'h0020_2013;

    logic        clk;
    logic        rst;
    logic [3:0]  err_code;
    logic        error;
    logic        halt;
    logic [63:0] inst_count;
    logic [63:0] cycle_count;
    logic [1:0]  meas_state;
    logic [3:0]  s_err_code;
    logic        s_error;
    logic        s_halt;
    logic [3:0]  s_inst_count;
    logic [3:0]  s_cycle_count;
    logic [1:0]  s_meas_state;

    int          n_tests;
    int          n_fail;
    logic [31:0] pc;
    logic [63:0] ord;

    rvfi_commit_checker_if #(.NRET(2)) bus ();

    rvfi_commit_checker #(.NRET(2), .CNT_W(64), .CHECK_PC(1'b1)) dut (
        .clk(clk), .rst(rst), .rvfi(bus), .err_code(err_code), .error(error),
        .halt(halt), .inst_count(inst_count), .cycle_count(cycle_count),
        .meas_state(meas_state));

    rvfi_commit_checker #(.NRET(2), .CNT_W(4), .CHECK_PC(1'b1)) dut_small (
        .clk(clk), .rst(rst), .rvfi(bus), .err_code(s_err_code), .error(s_error),
        .halt(s_halt), .inst_count(s_inst_count), .cycle_count(s_cycle_count),
        .meas_state(s_meas_state));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] pr0, input logic [31:0] pw0,
                         input logic [31:0] pr1, input logic [31:0] pw1);
        bus.valid    = v;
        bus.order    = {o1, o0};
        bus.inst     = {i1, i0};
        bus.pc_rdata = {pr1, pr0};
        bus.pc_wdata = {pw1, pw0};
        @(posedge clk);
        #1;
    endtask

    // Consistent commit: running order and a straight-line PC chain.
    task automatic commit(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        drive(v, ord, ord + 64'd1, i0, i1, pc, pc + 32'd4, pc + 32'd4, pc + 32'd8);
        ord = ord + ((v == 2'b11) ? 64'd2 : 64'd1);
        pc  = pc + ((v == 2'b11) ? 32'd8 : 32'd4);
    endtask

    task automatic idle_cycle();
        drive(2'b00, 64'd0, 64'd0, NOP, NOP, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        bus.valid = 2'b00;
        pc  = 32'h0000_1000;
        ord = 64'd0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (err_code !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err_code); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", halt); end
        n_tests++; if (meas_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", meas_state); end
        @(posedge clk);
        #1;
        n_tests++; if (inst_count !== 64'd0) begin n_fail++; $display("FAIL reset_inst: got %0d want 0", inst_count); end
        n_tests++; if (cycle_count !== 64'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d want 0", cycle_count); end
        rst = 1'b1;
    endtask

    task automatic test_clean_stream();
        do_reset();
        for (int k = 0; k < 4; k++) commit(2'b11, NOP, NOP);
        n_tests++; if (err_code !== 4'b0000) begin n_fail++; $display("FAIL clean_err: got %b want 0000", err_code); end
        n_tests++; if (inst_count !== 64'd8) begin n_fail++; $display("FAIL clean_inst: got %0d want 8", inst_count); end
        n_tests++; if (cycle_count !== 64'd4) begin n_fail++; $display("FAIL clean_cycle: got %0d want 4", cycle_count); end
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL clean_halt: got %b want 0", halt); end
    endtask

    task automatic test_gap();
        do_reset();
        drive(2'b10, 64'd0, 64'd1, NOP, NOP, 32'h100, 32'h104, 32'h104, 32'h108);
        n_tests++; if (err_code !== 4'b0001) begin n_fail++; $display("FAIL gap_err: got %b want 0001", err_code); end
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL gap_error: got %b want 1", error); end
        idle_cycle();
        idle_cycle();
        n_tests++; if (err_code !== 4'b0001) begin n_fail++; $display("FAIL gap_sticky: got %b want 0001", err_code); end
        rst = 1'b0;
        #1;
        n_tests++; if (err_code !== 4'b0000) begin n_fail++; $display("FAIL gap_clear: got %b want 0000", err_code); end
        rst = 1'b1;
    endtask

    task automatic test_order();
        do_reset();
        drive(2'b01, 64'd0, 64'd0, NOP, NOP, 32'h100, 32'h104, 32'h0, 32'h0);
        drive(2'b11, 64'd1, 64'd2, NOP, NOP, 32'h104, 32'h108, 32'h108, 32'h10c);
        n_tests++; if (err_code !== 4'b0000) begin n_fail++; $display("FAIL order_pre: got %b want 0000", err_code); end
        drive(2'b11, 64'd3, 64'd5, NOP, NOP, 32'h10c, 32'h110, 32'h110, 32'h114);
        n_tests++; if (err_code !== 4'b0010) begin n_fail++; $display("FAIL order_err: got %b want 0010", err_code); end
        drive(2'b11, 64'd5, 64'd6, NOP, NOP, 32'h114, 32'h118, 32'h118, 32'h11c);
        n_tests++; if (err_code !== 4'b0010) begin n_fail++; $display("FAIL order_resync: got %b want 0010", err_code); end
    endtask

    task automatic test_pc_chain();
        do_reset();
        commit(2'b11, NOP, NOP);
        drive(2'b01, 64'd2, 64'd0, NOP, NOP, 32'h2000, 32'h2004, 32'h0, 32'h0);
        n_tests++; if (err_code !== 4'b0100) begin n_fail++; $display("FAIL pc_cross: got %b want 0100", err_code); end
        do_reset();
        drive(2'b11, 64'd0, 64'd1, NOP, NOP, 32'h100, 32'h104, 32'h108, 32'h10c);
        n_tests++; if (err_code !== 4'b0100) begin n_fail++; $display("FAIL pc_intra: got %b want 0100", err_code); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(2'b11, 64'd0, 64'd1, JAL, NOP, 32'h100, 32'h200, 32'h200, 32'h204);
        n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_jal: got %b want 1", halt); end
        n_tests++; if (err_code !== 4'b0010) begin n_fail++; $display("FAIL halt_jal_err: got %b want 0010", err_code); end
        do_reset();
        drive(2'b01, 64'd0, 64'd0, NOP, NOP, 32'h300, 32'h300, 32'h0, 32'h0);
        n_tests++; if ({halt, err_code} !== 5'b1_0000) begin n_fail++; $display("FAIL halt_selfloop: got %b want 10000", {halt, err_code}); end
        drive(2'b01, 64'd1, 64'd0, NOP, NOP, 32'h300, 32'h304, 32'h0, 32'h0);
        n_tests++; if (err_code !== 4'b0010) begin n_fail++; $display("FAIL halt_post: got %b want 0010", err_code); end
        do_reset();
        commit(2'b11, NOP, BEQ);
        n_tests++; if ({halt, err_code} !== 5'b1_0000) begin n_fail++; $display("FAIL halt_beq_top: got %b want 10000", {halt, err_code}); end
    endtask

    task automatic test_measure();
        do_reset();
        commit(2'b11, NOP, START);
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd1, 64'd0, 64'd0}) begin n_fail++;
            $display("FAIL meas_start: got st=%0d i=%0d c=%0d want 1 0 0", meas_state, inst_count, cycle_count); end
        for (int k = 0; k < 3; k++) commit(2'b11, NOP, NOP);
        n_tests++; if ({inst_count, cycle_count} !== {64'd6, 64'd3}) begin n_fail++;
            $display("FAIL meas_run: got i=%0d c=%0d want 6 3", inst_count, cycle_count); end
        commit(2'b01, STOP, NOP);
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd2, 64'd7, 64'd4}) begin n_fail++;
            $display("FAIL meas_stop: got st=%0d i=%0d c=%0d want 2 7 4", meas_state, inst_count, cycle_count); end
        commit(2'b11, NOP, NOP);
        commit(2'b11, STOP, NOP);
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd2, 64'd7, 64'd4}) begin n_fail++;
            $display("FAIL meas_frozen: got st=%0d i=%0d c=%0d want 2 7 4", meas_state, inst_count, cycle_count); end
        n_tests++; if (err_code !== 4'b0000) begin n_fail++; $display("FAIL meas_err: got %b want 0000", err_code); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        commit(2'b11, START, STOP);
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd2, 64'd1, 64'd0}) begin n_fail++;
            $display("FAIL same_start_first: got st=%0d i=%0d c=%0d want 2 1 0", meas_state, inst_count, cycle_count); end
        commit(2'b11, STOP, START);
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd1, 64'd0, 64'd0}) begin n_fail++;
            $display("FAIL same_stop_first: got st=%0d i=%0d c=%0d want 1 0 0", meas_state, inst_count, cycle_count); end
        commit(2'b11, NOP, NOP);
        n_tests++; if ({inst_count, cycle_count} !== {64'd2, 64'd1}) begin n_fail++;
            $display("FAIL same_run_on: got i=%0d c=%0d want 2 1", inst_count, cycle_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) commit(2'b11, NOP, NOP);
        n_tests++; if ({inst_count, cycle_count} !== {64'd40, 64'd20}) begin n_fail++;
            $display("FAIL sat_wide: got i=%0d c=%0d want 40 20", inst_count, cycle_count); end
        n_tests++; if ({s_inst_count, s_cycle_count} !== {4'd15, 4'd15}) begin n_fail++;
            $display("FAIL sat_small: got i=%0d c=%0d want 15 15", s_inst_count, s_cycle_count); end
    endtask

    task automatic test_x_and_async_reset();
        logic [1:0] xv;
        logic       exp_x;
        do_reset();
        commit(2'b11, NOP, START);
        xv    = 2'bxx;
        exp_x = $isunknown(xv);
        bus.valid = xv;
        @(posedge clk);
        #1;
        n_tests++; if (err_code[3] !== exp_x) begin n_fail++; $display("FAIL x_valid: got %b want %b", err_code[3], exp_x); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if ({err_code, error, halt} !== 6'b0) begin n_fail++;
            $display("FAIL xrst_flags: got err=%b e=%b h=%b want 0", err_code, error, halt); end
        n_tests++; if ({meas_state, inst_count, cycle_count} !== {2'd0, 64'd0, 64'd0}) begin n_fail++;
            $display("FAIL xrst_meas: got st=%0d i=%0d c=%0d want 0 0 0", meas_state, inst_count, cycle_count); end
        bus.valid = 2'b00;
        rst = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pc  = 32'h0000_1000;
        ord = 64'd0;
        bus.valid    = 2'b00;
        bus.order    = 128'd0;
        bus.inst     = 64'd0;
        bus.pc_rdata = 64'd0;
        bus.pc_wdata = 64'd0;
        test_reset();
        test_clean_stream();
        test_gap();
        test_order();
        test_pc_chain();
        test_halt();
        test_measure();
        test_same_cycle();
        test_saturate();
        test_x_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_checker.md
RVFI_COMMIT_CHECKER -- requirements
Module: rvfi_commit_checker

Interface
REQ-001 SHALL have parameter NRET, default 2, number of retirement lanes per cycle (1..4).
REQ-002 SHALL have parameter CNT_W, default 64, width of the performance counters.
REQ-003 SHALL have parameter CHECK_PC, default 1; when set to 1 the PC-chain check is enabled.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid  input  NRET  per-lane commit strobe.
REQ-007 SHALL have port order  input  NRET*64  per-lane commit order; lane i is at [64*i +: 64].
REQ-008 SHALL have port inst  input  NRET*32  per-lane instruction word.
REQ-009 SHALL have port pc_rdata  input  NRET*32  per-lane PC of the instruction.
REQ-010 SHALL have port pc_wdata  input  NRET*32  per-lane next PC.
REQ-011 SHALL have port err_code  output  4  sticky error classes: [0] lane gap, [1] order/post-halt, [2] PC chain, [3] unknown (X) value.
REQ-012 SHALL have port error  output  1  equal to the OR of all err_code bits.
REQ-013 SHALL have port halt  output  1  sticky halt indication.
REQ-014 SHALL have port inst_count  output  CNT_W  retired-instruction counter.
REQ-015 SHALL have port cycle_count  output  CNT_W  cycle counter.
REQ-016 SHALL have port meas_state  output  2  measurement state: 0 IDLE, 1 RUN, 2 DONE.

Function
REQ-017 SHALL evaluate all checks on every clk edge while rst=1; every output updates on the edge after the offending or triggering commit cycle (1-cycle latency).
REQ-018 SHALL set err_code[3] if valid contains an X, or if any valid lane's order, inst, pc_rdata or pc_wdata contains an X.
REQ-019 SHALL require valid to be a prefix (lanes 0..k-1 set, all others clear); any gap, e.g. 2'b10, SHALL set err_code[0].
REQ-020 SHALL keep a 64-bit exp_order, 0 after reset; valid lane i SHALL carry order == exp_order+i, else err_code[1] is set.
REQ-021 SHALL advance exp_order by popcount(valid) each cycle, whether or not a mismatch occurred.
REQ-022 When CHECK_PC=1, SHALL set err_code[2] if lane i>0 has pc_rdata != pc_wdata of lane i-1 in the same cycle.
REQ-023 When CHECK_PC=1, SHALL set err_code[2] if lane 0 has pc_rdata != last_pc, where last_pc is the pc_wdata of the highest valid lane of the previous commit cycle; this check is skipped for the first commit after reset.
REQ-024 SHALL set halt when any valid lane has pc_rdata==pc_wdata, inst==32'h00000063, or inst==32'h0000006f.
REQ-025 SHALL set err_code[1] for any valid commit while halt=1; valid lanes above the halting lane in the halting cycle SHALL also set err_code[1].
REQ-026 err_code bits and halt SHALL be sticky until reset; error SHALL be combinationally derived from the registered err_code.
REQ-027 Start marker is inst 32'h00102013; stop marker is inst 32'h00202013; the lowest valid lane carrying a marker is taken.
REQ-028 In IDLE, cycle_count SHALL increment by 1 each cycle and inst_count by popcount(valid).
REQ-029 On a start marker in IDLE, RUN or DONE, SHALL go to RUN with cycle_count<=0 and inst_count<=number of valid lanes above the start lane.
REQ-030 In RUN, counters SHALL update as in IDLE.
REQ-031 On a stop marker in RUN, SHALL add the valid lanes up to and including the stop lane, add 1 cycle, go to DONE, and freeze both counters.
REQ-032 A stop marker SHALL be ignored in IDLE and in DONE; in DONE the counters hold.
REQ-033 If start and stop markers occur in the same cycle with start lane < stop lane, SHALL go to DONE with inst_count=stop_lane-start_lane and cycle_count=0.
REQ-034 If start and stop markers occur in the same cycle with stop lane < start lane, the stop marker SHALL be ignored and REQ-029 applies.
REQ-035 Counters SHALL saturate at all-ones and not wrap.

Reset
REQ-036 On rst=0 (asynchronous), SHALL immediately set err_code=0, error=0, halt=0, inst_count=0, cycle_count=0, meas_state=IDLE, exp_order=0, and clear last_pc valid.
REQ-037 Reset asserted mid-RUN SHALL discard the measurement; no check fires in a cycle with rst=0.

Verification
REQ-038 NRET=2, four cycles of two lanes each with orders 0..7 and a consistent PC chain -> err_code=0 and inst_count=8 after the fourth edge.
REQ-039 valid=2'b10 -> err_code[0]=1 one edge later; err_code stays 1 until rst=0.
REQ-040 Lane 1 commits order 5 when exp_order=3 -> err_code[1]=1; next cycle with correct order 5 (exp_order advanced to 5) -> no further new error bit.
REQ-041 Lane 0 commits inst 32'h0000006f while lane 1 is valid -> halt=1 and err_code[1]=1 on the next edge.
REQ-042 Start marker in lane 1, then 3 cycles of 2 lanes, then stop marker in lane 0 -> meas_state=DONE, inst_count=7, cycle_count=4; further commits leave both counters unchanged.
REQ-043 Drive X on valid; then assert rst=0 between edges -> err_code[3]=1; on reset all outputs read 0 and meas_state reads IDLE without waiting for a clk edge.
